// File: rtl/ebpc_pkg.sv
// Shared types and constants for the EBPC encoder back end.
package ebpc_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    OPEN_BOTH,
    ZNZ_ONLY,
    BPC_ONLY
  } merge_state_t;

  localparam logic SRC_ZNZ = 1'b0;
  localparam logic SRC_BPC = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              src;
    logic              last;
  } merge_word_t;

endpackage

// File: rtl/ebpc_skid_buf.sv
// Two-entry register slice for the merged stream; ent0 is always the head.
module ebpc_skid_buf
  import ebpc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  merge_word_t in_word_i,
  input  logic        in_vld_i,
  output logic        in_rdy_o,
  output merge_word_t out_word_o,
  output logic        out_vld_o,
  input  logic        out_rdy_i,
  output logic        full_o,
  output logic        empty_o
);

  merge_word_t ent0_q, ent0_d;
  merge_word_t ent1_q, ent1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        push, pop;

  assign full_o     = (cnt_q == 2'd2);
  assign empty_o    = (cnt_q == 2'd0);
  assign in_rdy_o   = !full_o;
  assign out_vld_o  = !empty_o;
  assign out_word_o = ent0_q;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    push   = in_vld_i && in_rdy_o;
    pop    = out_vld_o && out_rdy_i;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = in_word_i;
        else               ent1_d = in_word_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // count stays; the new word lands behind whatever remains
        if (cnt_q == 2'd1) begin
          ent0_d = in_word_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = in_word_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ebpc_stream_merger.sv
// Merges the ZNZ and BPC encoder streams into one tagged stream, one last_o per frame.
//   state     | meaning
//   OPEN_BOTH | both streams may deliver words
//   ZNZ_ONLY  | BPC has delivered its last word, waiting for ZNZ last
//   BPC_ONLY  | ZNZ has delivered its last word, waiting for BPC last
module ebpc_stream_merger
  import ebpc_pkg::*;
#(
  parameter int unsigned CNT_W = 24
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] znz_data_i,
  input  logic              znz_last_i,
  input  logic              znz_vld_i,
  output logic              znz_rdy_o,
  input  logic [DATA_W-1:0] bpc_data_i,
  input  logic              bpc_last_i,
  input  logic              bpc_vld_i,
  output logic              bpc_rdy_o,
  output logic [DATA_W-1:0] data_o,
  output logic              src_o,
  output logic              last_o,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic              idle_o,
  output logic [CNT_W-1:0]  znz_cnt_o,
  output logic [CNT_W-1:0]  bpc_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  merge_state_t     state_q, state_d;
  logic             rr_q, rr_d;
  logic             frame_q, frame_d;
  logic [CNT_W-1:0] znz_cnt_q, znz_cnt_d;
  logic [CNT_W-1:0] bpc_cnt_q, bpc_cnt_d;
  logic [CNT_W-1:0] znz_base, bpc_base;

  logic znz_elig, bpc_elig, gnt_znz, gnt_bpc, acc, acc_last;
  logic buf_rdy, buf_full, buf_empty;
  merge_word_t in_word, out_word;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    frame_d   = frame_q;
    znz_cnt_d = znz_cnt_q;
    bpc_cnt_d = bpc_cnt_q;

    znz_elig  = znz_vld_i && (state_q != BPC_ONLY);
    bpc_elig  = bpc_vld_i && (state_q != ZNZ_ONLY);
    gnt_znz   = znz_elig && (!bpc_elig || (rr_q == SRC_ZNZ));
    gnt_bpc   = bpc_elig && !gnt_znz;
    znz_rdy_o = gnt_znz && buf_rdy;
    bpc_rdy_o = gnt_bpc && buf_rdy;
    acc       = znz_rdy_o || bpc_rdy_o;
    acc_last  = gnt_bpc ? bpc_last_i : znz_last_i;

    in_word.data = gnt_bpc ? bpc_data_i : znz_data_i;
    in_word.src  = gnt_bpc ? SRC_BPC : SRC_ZNZ;
    // only the stream that finishes second closes the frame
    in_word.last = acc_last && (state_q != OPEN_BOTH);

    znz_base = frame_q ? znz_cnt_q : '0;
    bpc_base = frame_q ? bpc_cnt_q : '0;

    if (acc) begin
      frame_d = 1'b1;
      if (znz_elig && bpc_elig) rr_d = !rr_q;
      znz_cnt_d = (gnt_znz && (znz_base != CNT_MAX)) ? znz_base + CNT_ONE : znz_base;
      bpc_cnt_d = (gnt_bpc && (bpc_base != CNT_MAX)) ? bpc_base + CNT_ONE : bpc_base;
      if (acc_last) begin
        if (state_q == OPEN_BOTH) begin
          state_d = gnt_bpc ? ZNZ_ONLY : BPC_ONLY;
        end else begin
          state_d = OPEN_BOTH;
          frame_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= OPEN_BOTH;
      rr_q      <= SRC_ZNZ;
      frame_q   <= 1'b0;
      znz_cnt_q <= '0;
      bpc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      frame_q   <= frame_d;
      znz_cnt_q <= znz_cnt_d;
      bpc_cnt_q <= bpc_cnt_d;
    end
  end

  ebpc_skid_buf u_skid_buf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_word_i  (in_word),
    .in_vld_i   (gnt_znz || gnt_bpc),
    .in_rdy_o   (buf_rdy),
    .out_word_o (out_word),
    .out_vld_o  (vld_o),
    .out_rdy_i  (rdy_i),
    .full_o     (buf_full),
    .empty_o    (buf_empty)
  );

  assign data_o    = out_word.data;
  assign src_o     = out_word.src;
  assign last_o    = out_word.last;
  assign idle_o    = (state_q == OPEN_BOTH) && !frame_q && buf_empty;
  assign znz_cnt_o = znz_cnt_q;
  assign bpc_cnt_o = bpc_cnt_q;

endmodule

// File: tb/tb_ebpc_stream_merger.sv
// Directed bench for ebpc_stream_merger: queued input streams, expected output lists.
module tb_ebpc_stream_merger;
  import ebpc_pkg::*;

  localparam int CW = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [DATA_W-1:0] znz_data_i = '0;
  logic              znz_last_i = 1'b0;
  logic              znz_vld_i = 1'b0;
  logic              znz_rdy_o;
  logic [DATA_W-1:0] bpc_data_i = '0;
  logic              bpc_last_i = 1'b0;
  logic              bpc_vld_i = 1'b0;
  logic              bpc_rdy_o;
  logic [DATA_W-1:0] data_o;
  logic              src_o;
  logic              last_o;
  logic              vld_o;
  logic              rdy_i = 1'b1;
  logic              idle_o;
  logic [CW-1:0]     znz_cnt_o;
  logic [CW-1:0]     bpc_cnt_o;

  ebpc_stream_merger #(.CNT_W(CW)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .znz_data_i (znz_data_i),
    .znz_last_i (znz_last_i),
    .znz_vld_i  (znz_vld_i),
    .znz_rdy_o  (znz_rdy_o),
    .bpc_data_i (bpc_data_i),
    .bpc_last_i (bpc_last_i),
    .bpc_vld_i  (bpc_vld_i),
    .bpc_rdy_o  (bpc_rdy_o),
    .data_o     (data_o),
    .src_o      (src_o),
    .last_o     (last_o),
    .vld_o      (vld_o),
    .rdy_i      (rdy_i),
    .idle_o     (idle_o),
    .znz_cnt_o  (znz_cnt_o),
    .bpc_cnt_o  (bpc_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int dual = 0;
  int fz = 0, fb = 0;
  logic zdone = 1'b0, bdone = 1'b0;

  logic [DATA_W-1:0] zq[$], bq[$], od[$], ed[$];
  logic              zlq[$], blq[$], os[$], es[$], ol[$], el[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_inputs();
    znz_vld_i  = (zq.size() > 0);
    znz_data_i = '0;
    znz_last_i = 1'b0;
    if (znz_vld_i) begin
      znz_data_i = zq[0];
      znz_last_i = zlq[0];
    end
    bpc_vld_i  = (bq.size() > 0);
    bpc_data_i = '0;
    bpc_last_i = 1'b0;
    if (bpc_vld_i) begin
      bpc_data_i = bq[0];
      bpc_last_i = blq[0];
    end
  endtask

  // one clock: present heads, observe handshakes before the edge, pop after it
  task automatic step();
    logic za, ba;
    apply_inputs();
    #1;
    za = znz_vld_i && znz_rdy_o;
    ba = bpc_vld_i && bpc_rdy_o;
    if (za && ba) dual++;
    if (vld_o && rdy_i) begin
      od.push_back(data_o);
      os.push_back(src_o);
      ol.push_back(last_o);
    end
    if (za) begin
      acc_cnt++;
      fz++;
      if (znz_last_i) zdone = 1'b1;
    end
    if (ba) begin
      acc_cnt++;
      fb++;
      if (bpc_last_i) bdone = 1'b1;
    end
    if (zdone && bdone) begin
      assert (fz > 0 && fb > 0) else $error("frame closed with an empty stream");
      fz = 0;
      fb = 0;
      zdone = 1'b0;
      bdone = 1'b0;
    end
    @(posedge clk_i);
    #1;
    if (za) begin
      void'(zq.pop_front());
      void'(zlq.pop_front());
    end
    if (ba) begin
      void'(bq.pop_front());
      void'(blq.pop_front());
    end
    apply_inputs();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((zq.size() > 0 || bq.size() > 0 || vld_o) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic pz(input logic [DATA_W-1:0] d, input logic l);
    zq.push_back(d);
    zlq.push_back(l);
  endtask

  task automatic pb(input logic [DATA_W-1:0] d, input logic l);
    bq.push_back(d);
    blq.push_back(l);
  endtask

  task automatic ew(input logic [DATA_W-1:0] d, input logic s, input logic l);
    ed.push_back(d);
    es.push_back(s);
    el.push_back(l);
  endtask

  task automatic cmp_out(input string tag);
    int n;
    chk({tag, "_count"}, 32'(od.size()), 32'(ed.size()));
    n = (od.size() < ed.size()) ? od.size() : ed.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), od[i], ed[i]);
      chk($sformatf("%s_src%0d", tag, i), 32'(os[i]), 32'(es[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(ol[i]), 32'(el[i]));
    end
    od.delete(); os.delete(); ol.delete();
    ed.delete(); es.delete(); el.delete();
  endtask

  initial begin
    int acc0, unstable;

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_vld", 32'(vld_o), 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("rst_last", 32'(last_o), 32'd0);
    chk("rst_src", 32'(src_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_idle", 32'(idle_o), 32'd1);
    chk("rst_zcnt", 32'(znz_cnt_o), 32'd0);
    chk("rst_bcnt", 32'(bpc_cnt_o), 32'd0);

    // alternating streams
    pz(32'h11, 0); pz(32'h12, 1);
    pb(32'hA1, 0); pb(32'hA2, 0); pb(32'hA3, 1);
    ew(32'h11, 0, 0); ew(32'hA1, 1, 0); ew(32'h12, 0, 0); ew(32'hA2, 1, 0); ew(32'hA3, 1, 1);
    drain(40);
    cmp_out("alt");
    chk("alt_zcnt", 32'(znz_cnt_o), 32'd2);
    chk("alt_bcnt", 32'(bpc_cnt_o), 32'd3);
    chk("alt_idle", 32'(idle_o), 32'd1);

    // single-word ZNZ frame, next-frame ZNZ blocked until BPC closes
    pz(32'h21, 1); pz(32'h31, 0); pz(32'h32, 1);
    pb(32'hB1, 0); pb(32'hB2, 0); pb(32'hB3, 1); pb(32'hC1, 1);
    step();
    step();
    #1;
    chk("single_znz_blocked", 32'(znz_rdy_o), 32'd0);
    chk("single_bpc_open", 32'(bpc_rdy_o), 32'd1);
    ew(32'hB1, 1, 0); ew(32'h21, 0, 0); ew(32'hB2, 1, 0); ew(32'hB3, 1, 1);
    ew(32'hC1, 1, 0); ew(32'h31, 0, 0); ew(32'h32, 0, 1);
    drain(40);
    cmp_out("single");
    chk("single_zcnt", 32'(znz_cnt_o), 32'd2);
    chk("single_bcnt", 32'(bpc_cnt_o), 32'd1);

    // backpressure
    rdy_i = 1'b0;
    acc0 = acc_cnt;
    unstable = 0;
    pz(32'h41, 0); pz(32'h42, 1);
    pb(32'hD1, 0); pb(32'hD2, 1);
    repeat (5) begin
      step();
      if (vld_o && data_o !== 32'h41) unstable++;
    end
    #1;
    chk("bp_vld", 32'(vld_o), 32'd1);
    chk("bp_data", data_o, 32'h41);
    chk("bp_src", 32'(src_o), 32'd0);
    chk("bp_stable", 32'(unstable), 32'd0);
    chk("bp_accepted", 32'(acc_cnt - acc0), 32'd2);
    chk("bp_znz_rdy", 32'(znz_rdy_o), 32'd0);
    chk("bp_bpc_rdy", 32'(bpc_rdy_o), 32'd0);
    rdy_i = 1'b1;
    ew(32'h41, 0, 0); ew(32'hD1, 1, 0); ew(32'h42, 0, 0); ew(32'hD2, 1, 1);
    drain(40);
    cmp_out("bp");
    chk("bp_zcnt", 32'(znz_cnt_o), 32'd2);
    chk("bp_bcnt", 32'(bpc_cnt_o), 32'd2);

    // simultaneous lasts
    pz(32'h51, 1);
    pb(32'hE1, 1);
    ew(32'hE1, 1, 0); ew(32'h51, 0, 1);
    drain(20);
    cmp_out("sim");
    chk("sim_idle", 32'(idle_o), 32'd1);
    chk("sim_zcnt", 32'(znz_cnt_o), 32'd1);
    chk("sim_bcnt", 32'(bpc_cnt_o), 32'd1);

    // reset mid-frame
    pz(32'h61, 0); pz(32'h62, 0); pz(32'h63, 0); pz(32'h64, 1);
    repeat (3) step();
    chk("rmid_pre_vld", 32'(vld_o), 32'd1);
    chk("rmid_pre_zcnt", 32'(znz_cnt_o), 32'd3);
    #1 rst_ni = 1'b0;
    #1;
    chk("rmid_vld", 32'(vld_o), 32'd0);
    chk("rmid_last", 32'(last_o), 32'd0);
    chk("rmid_zcnt", 32'(znz_cnt_o), 32'd0);
    chk("rmid_bcnt", 32'(bpc_cnt_o), 32'd0);
    zq.delete(); zlq.delete(); bq.delete(); blq.delete();
    od.delete(); os.delete(); ol.delete();
    fz = 0; fb = 0; zdone = 1'b0; bdone = 1'b0;
    apply_inputs();
    #2 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    pz(32'h71, 1);
    pb(32'hF1, 1);
    step();
    chk("rmid_first_zcnt", 32'(znz_cnt_o), 32'd1);
    chk("rmid_first_bcnt", 32'(bpc_cnt_o), 32'd0);
    ew(32'h71, 0, 0); ew(32'hF1, 1, 1);
    drain(20);
    cmp_out("rmid");
    chk("rmid_zcnt_end", 32'(znz_cnt_o), 32'd1);
    chk("rmid_bcnt_end", 32'(bpc_cnt_o), 32'd1);

    // counter saturation (CNT_W=4)
    for (int i = 0; i < 20; i++) begin
      pz(32'h80 + 32'(i), (i == 19));
      ew(32'h80 + 32'(i), 0, 0);
    end
    drain(80);
    cmp_out("sat");
    chk("sat_zcnt", 32'(znz_cnt_o), 32'd15);
    pb(32'hF9, 1);
    ew(32'hF9, 1, 1);
    drain(20);
    cmp_out("sat_close");
    chk("sat_zcnt_hold", 32'(znz_cnt_o), 32'd15);
    chk("sat_bcnt", 32'(bpc_cnt_o), 32'd1);
    chk("sat_idle", 32'(idle_o), 32'd1);

    chk("dual_grant", 32'(dual), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
